// File: rtl/jtframe_rom_arb_pkg.sv
// jtframe_rom_arb_pkg
// Shared types and helpers for the SDRAM ROM read arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT_ACK, WAIT_DATA)
//   fixed_pri   : lowest set index of a request mask (slot 0 wins)
//   next_rr     : first set index strictly after ptr, wrapping around
// Masks are always passed at MAX_SLOTS width with unused bits at zero. A
// wrap at MAX_SLOTS therefore gives the same order as a wrap at SLOTS.
package jtframe_rom_arb_pkg;

    localparam int MAX_SLOTS = 16;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    function automatic logic [IDX_W-1:0] fixed_pri(input logic [MAX_SLOTS-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SLOTS-1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [IDX_W-1:0] next_rr(input logic [MAX_SLOTS-1:0] mask,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        // cand wraps naturally at 2^IDX_W == MAX_SLOTS; k == MAX_SLOTS revisits ptr last
        for (int k = 1; k <= MAX_SLOTS; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtframe_rom_arb_if.sv
// jtframe_rom_arb_if
// Bundles the client-side ROM slots and the SDRAM controller read port.
//   slave  : the arbiter's view (takes client requests and controller responses)
//   master : the environment's view (clients plus SDRAM controller)
// Signals:
//   downloading            ROM load in progress; invalidates all slots
//   slot_cs/slot_addr      per-slot request enable and packed address
//   slot_ok/slot_dout      per-slot data valid and packed 16-bit data
//   sdram_req/sdram_addr   read request and word address
//   sdram_ack              request accepted
//   data_dst/data_rdy      burst start (unused) and read data valid
//   data_read              SDRAM read data
interface jtframe_rom_arb_if #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int SAW   = 18
);
    logic                 downloading;
    logic [SLOTS-1:0]     slot_cs;
    logic [SLOTS*SAW-1:0] slot_addr;
    logic [SLOTS-1:0]     slot_ok;
    logic [SLOTS*16-1:0]  slot_dout;
    logic                 sdram_req;
    logic [AW-1:0]        sdram_addr;
    logic                 sdram_ack;
    logic                 data_dst;
    logic                 data_rdy;
    logic [15:0]          data_read;

    modport slave (
        input  downloading, slot_cs, slot_addr, sdram_ack, data_dst, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr
    );

    modport master (
        output downloading, slot_cs, slot_addr, sdram_ack, data_dst, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtframe_rom_arb_slot.sv
// jtframe_rom_arb_slot
// One client slot: a single-word cache (valid/tag/data) with hit detection.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   downloading  clears the valid bit
//   cs, addr     client request enable and address (byte or word address)
//   wr           fill strobe from the arbiter; wr_tag/wr_data are the new contents
//   wa           word address derived from addr
//   full_addr    OFFSET + wa, wrapping modulo 2^AW
//   pend         client wants data that is not cached
//   ok, dout     data valid for the current address, and the data
module jtframe_rom_arb_slot #(
    parameter int            AW     = 22,
    parameter int            SAW    = 18,
    parameter bit            BYTE   = 1'b0,
    parameter logic [AW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,
    input  logic           cs,
    input  logic [SAW-1:0] addr,
    input  logic           wr,
    input  logic [SAW-1:0] wr_tag,
    input  logic [15:0]    wr_data,
    output logic [SAW-1:0] wa,
    output logic [AW-1:0]  full_addr,
    output logic           pend,
    output logic           ok,
    output logic [15:0]    dout
);

    logic           valid;
    logic [SAW-1:0] tag;
    logic [15:0]    data;
    logic           hit;

    assign wa        = BYTE ? {1'b0, addr[SAW-1:1]} : addr;
    assign full_addr = OFFSET + AW'(wa);

    assign hit  = valid && (tag == wa);
    assign pend = cs && !hit;
    assign ok   = cs && hit && !downloading;

    // Byte slots pick the lane from the address LSB and zero-extend.
    assign dout = BYTE ? {8'h00, (addr[0] ? data[15:8] : data[7:0])} : data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (downloading) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= wr_data;
        end
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb
// SDRAM read arbiter for SLOTS ROM clients, each with a one-word cache.
// Cache hits are answered combinationally. Misses are queued to the SDRAM
// controller one at a time, using fixed priority (RR=0) or round-robin (RR=1).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  jtframe_rom_arb_if.slave (client slots plus SDRAM read port)
// Parameters: SLOTS, AW (SDRAM word address width), SAW (slot address width),
//   BYTE_MASK (bit i set = 8-bit slot), OFFSETS (slot i base at [i*AW +: AW]),
//   RR (arbitration mode).
module jtframe_rom_arb #(
    parameter int                  SLOTS     = 4,
    parameter int                  AW        = 22,
    parameter int                  SAW       = 18,
    parameter logic [SLOTS-1:0]    BYTE_MASK = '0,
    parameter logic [SLOTS*AW-1:0] OFFSETS   = '0,
    parameter bit                  RR        = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    jtframe_rom_arb_if.slave   bus
);

    import jtframe_rom_arb_pkg::*;

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IDX_W-1:0]     sel;
    logic [IDX_W-1:0]     sel_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [SAW-1:0]       tag_lat;
    logic [AW-1:0]        req_addr;
    logic                 req;
    logic                 fill;
    logic                 start;

    logic [SLOTS-1:0]     pend;
    logic [MAX_SLOTS-1:0] pend_ext;
    logic [SLOTS-1:0]     ok_v;
    logic [SLOTS*16-1:0]  dout_v;
    logic [SAW-1:0]       wa_arr [MAX_SLOTS];
    logic [AW-1:0]        fa_arr [MAX_SLOTS];

    // The controller's burst-start strobe carries no information here.
    logic                 unused_dst;
    assign unused_dst = bus.data_dst;

    // Arrays are sized for MAX_SLOTS so the 4-bit selection index always fits.
    for (genvar i = 0; i < MAX_SLOTS; i++) begin : g_slot
        if (i < SLOTS) begin : g_on
            jtframe_rom_arb_slot #(
                .AW     (AW),
                .SAW    (SAW),
                .BYTE   (BYTE_MASK[i]),
                .OFFSET (OFFSETS[i*AW +: AW])
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .downloading (bus.downloading),
                .cs          (bus.slot_cs[i]),
                .addr        (bus.slot_addr[i*SAW +: SAW]),
                .wr          (fill && (sel == IDX_W'(i))),
                .wr_tag      (tag_lat),
                .wr_data     (bus.data_read),
                .wa          (wa_arr[i]),
                .full_addr   (fa_arr[i]),
                .pend        (pend[i]),
                .ok          (ok_v[i]),
                .dout        (dout_v[i*16 +: 16])
            );
        end else begin : g_off
            assign wa_arr[i] = '0;
            assign fa_arr[i] = '0;
        end
    end

    assign bus.slot_ok    = ok_v;
    assign bus.slot_dout  = dout_v;
    assign bus.sdram_req  = req;
    assign bus.sdram_addr = req_addr;

    assign pend_ext = MAX_SLOTS'(pend);
    assign sel_nxt  = RR ? next_rr(pend_ext, ptr) : fixed_pri(pend_ext);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a download aborts any fetch in flight
    always_comb begin
        state_nxt = state;
        if (bus.downloading) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (|pend) state_nxt = WAIT_ACK;
                // ack and data together count as ack followed by data
                WAIT_ACK:  if (bus.sdram_ack) state_nxt = bus.data_rdy ? IDLE : WAIT_DATA;
                WAIT_DATA: if (bus.data_rdy) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        req   = (state == WAIT_ACK);
        start = !bus.downloading && (state == IDLE) && (|pend);
        fill  = !bus.downloading && bus.data_rdy &&
                ((state == WAIT_DATA) || ((state == WAIT_ACK) && bus.sdram_ack));
    end

    // Request latch. The tag is captured here so a fill lands on the address
    // that was actually fetched, even if the client moved on meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            tag_lat  <= '0;
            req_addr <= '0;
            ptr      <= IDX_W'(SLOTS-1);
        end else if (start) begin
            sel      <= sel_nxt;
            tag_lat  <= wa_arr[sel_nxt];
            req_addr <= fa_arr[sel_nxt];
            ptr      <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
`timescale 1ns/1ps
module tb_jtframe_rom_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int SAW   = 18;
    localparam logic [SLOTS-1:0]    BYTE_MASK = 4'b0100;
    localparam logic [SLOTS*AW-1:0] OFFSETS   =
        {22'h100000, 22'h3FFFF0, 22'h020000, 22'h000000};
    localparam int NCYC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Stimulus shared by both arbiters (d=0: fixed priority, d=1: round-robin)
    logic             dl, ack, rdy, dst;
    logic [15:0]      rdata;
    logic [SLOTS-1:0] cs_v;
    int               addr_v [SLOTS];
    logic [SLOTS*SAW-1:0] addr_pk;
    int               dl_cnt;
    int               pool [8] = '{32'h00010, 32'h00011, 32'h00020, 32'h00021,
                                   32'h00100, 32'h00101, 32'h3FFFF, 32'h3FFFE};

    for (genvar i = 0; i < SLOTS; i++) begin : g_pk
        assign addr_pk[i*SAW +: SAW] = SAW'(addr_v[i]);
    end

    jtframe_rom_arb_if #(.SLOTS(SLOTS), .AW(AW), .SAW(SAW)) bus0 ();
    jtframe_rom_arb_if #(.SLOTS(SLOTS), .AW(AW), .SAW(SAW)) bus1 ();

    assign bus0.downloading = dl;    assign bus1.downloading = dl;
    assign bus0.slot_cs     = cs_v;  assign bus1.slot_cs     = cs_v;
    assign bus0.slot_addr   = addr_pk; assign bus1.slot_addr = addr_pk;
    assign bus0.sdram_ack   = ack;   assign bus1.sdram_ack   = ack;
    assign bus0.data_dst    = dst;   assign bus1.data_dst    = dst;
    assign bus0.data_rdy    = rdy;   assign bus1.data_rdy    = rdy;
    assign bus0.data_read   = rdata; assign bus1.data_read   = rdata;

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .SAW(SAW), .BYTE_MASK(BYTE_MASK),
                      .OFFSETS(OFFSETS), .RR(1'b0))
        u_fix (.clk(clk), .rst(rst), .bus(bus0));

    jtframe_rom_arb #(.SLOTS(SLOTS), .AW(AW), .SAW(SAW), .BYTE_MASK(BYTE_MASK),
                      .OFFSETS(OFFSETS), .RR(1'b1))
        u_rr  (.clk(clk), .rst(rst), .bus(bus1));

    logic                req_w   [2];
    logic [AW-1:0]       saddr_w [2];
    logic [SLOTS-1:0]    ok_w    [2];
    logic [SLOTS*16-1:0] dout_w  [2];
    assign req_w[0] = bus0.sdram_req;  assign req_w[1] = bus1.sdram_req;
    assign saddr_w[0] = bus0.sdram_addr; assign saddr_w[1] = bus1.sdram_addr;
    assign ok_w[0] = bus0.slot_ok;     assign ok_w[1] = bus1.slot_ok;
    assign dout_w[0] = bus0.slot_dout; assign dout_w[1] = bus1.slot_dout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int m_valid [2][SLOTS];
    int m_tag   [2][SLOTS];
    int m_data  [2][SLOTS];
    int m_busy  [2];
    int m_acked [2];
    int m_sel   [2];
    int m_ltag  [2];
    int m_addr  [2];
    int m_ptr   [2];

    function automatic int wa_of(input int i, input int a);
        return BYTE_MASK[i] ? a / 2 : a;
    endfunction

    function automatic int sd_of(input int i, input int a);
        int off;
        off = int'(OFFSETS[i*AW +: AW]);
        return (off + wa_of(i, a)) % (1 << AW);
    endfunction

    function automatic bit m_hit(input int d, input int i);
        return (m_valid[d][i] != 0) && (m_tag[d][i] == wa_of(i, addr_v[i]));
    endfunction

    function automatic bit m_pend(input int d, input int i);
        return cs_v[i] && !m_hit(d, i);
    endfunction

    // d=0 picks the lowest pending index, d=1 the first one after the last served
    function automatic int m_pick(input int d);
        int s;
        s = -1;
        if (d == 0) begin
            for (int i = SLOTS-1; i >= 0; i--) if (m_pend(d, i)) s = i;
        end else begin
            for (int k = SLOTS; k >= 1; k--)
                if (m_pend(d, (m_ptr[d] + k) % SLOTS)) s = (m_ptr[d] + k) % SLOTS;
        end
        return s;
    endfunction

    function automatic int m_dout(input int d, input int i);
        int v;
        v = m_data[d][i];
        if (BYTE_MASK[i]) return (addr_v[i] % 2 != 0) ? (v >> 8) & 255 : v & 255;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < SLOTS; i++) begin
                    m_valid[d][i] <= 0; m_tag[d][i] <= 0; m_data[d][i] <= 0;
                end
                m_busy[d] <= 0; m_acked[d] <= 0; m_ptr[d] <= SLOTS-1;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (dl) begin
                    for (int i = 0; i < SLOTS; i++) m_valid[d][i] <= 0;
                    m_busy[d] <= 0;
                end else if (m_busy[d] != 0 && rdy && (m_acked[d] != 0 || ack)) begin
                    m_valid[d][m_sel[d]] <= 1;
                    m_tag[d][m_sel[d]]   <= m_ltag[d];
                    m_data[d][m_sel[d]]  <= int'(rdata);
                    m_busy[d]            <= 0;
                end else if (m_busy[d] != 0 && m_acked[d] == 0 && ack) begin
                    m_acked[d] <= 1;
                end else if (m_busy[d] == 0 && m_pick(d) >= 0) begin
                    m_sel[d]   <= m_pick(d);
                    m_ltag[d]  <= wa_of(m_pick(d), addr_v[m_pick(d)]);
                    m_addr[d]  <= sd_of(m_pick(d), addr_v[m_pick(d)]);
                    m_ptr[d]   <= m_pick(d);
                    m_busy[d]  <= 1;
                    m_acked[d] <= 0;
                end
            end
        end
    end

    task automatic check_outputs();
        bit exp_req, exp_ok;
        for (int d = 0; d < 2; d++) begin
            exp_req = (m_busy[d] != 0) && (m_acked[d] == 0);
            chk($sformatf("req%0d", d), 32'(req_w[d]), 32'(exp_req));
            if (exp_req) chk($sformatf("addr%0d", d), 32'(saddr_w[d]), 32'(m_addr[d]));
            for (int i = 0; i < SLOTS; i++) begin
                exp_ok = cs_v[i] && m_hit(d, i) && !dl;
                chk($sformatf("ok%0d_%0d", d, i), 32'(ok_w[d][i]), 32'(exp_ok));
                if (exp_ok)
                    chk($sformatf("dout%0d_%0d", d, i), 32'(dout_w[d][i*16 +: 16]),
                        32'(m_dout(d, i)));
            end
        end
    endtask

    task automatic drive_random(input bit hold);
        for (int i = 0; i < SLOTS; i++) begin
            if ($urandom_range(7) == 0) cs_v[i] = ~cs_v[i];
            if ($urandom_range(9) == 0) addr_v[i] = pool[$urandom_range(7)];
        end
        ack   = hold ? 1'b0 : ($urandom_range(2) == 0);
        rdy   = ($urandom_range(2) == 0);
        rdata = 16'($urandom);
        dst   = 1'($urandom_range(1));
        if (hold) begin
            dl = 1'b0; dl_cnt = 0;
        end else if (dl_cnt > 0) begin
            dl = 1'b1; dl_cnt--;
        end else begin
            dl = 1'b0;
            if ($urandom_range(199) == 0) dl_cnt = $urandom_range(5, 1);
        end
    endtask

    initial begin
        int  w;
        cs_v = '1; ack = 0; rdy = 0; dst = 0; dl = 0; rdata = '0; dl_cnt = 0;
        for (int i = 0; i < SLOTS; i++) addr_v[i] = pool[i*2];
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req%0d", d),  32'(req_w[d]), 0);
            chk($sformatf("rst_addr%0d", d), 32'(saddr_w[d]), 0);
            chk($sformatf("rst_ok%0d", d),   32'(ok_w[d]), 0);
            chk($sformatf("rst_dout%0d", d), dout_w[d][31:0], 0);
        end
        rst = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            check_outputs();
            if (c == NCYC/2) begin
                // Hold off ack until the fixed-priority arbiter is waiting for one
                w = 0;
                while (w < 200 && !(m_busy[0] != 0 && m_acked[0] == 0)) begin
                    drive_random(1'b1);
                    @(negedge clk);
                    check_outputs();
                    w++;
                end
                chk("rst_in_wait_ack", 32'(w < 200), 1);
                #2 rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("arst_req%0d", d), 32'(req_w[d]), 0);
                    chk($sformatf("arst_ok%0d", d),  32'(ok_w[d]), 0);
                end
                #1 rst = 1'b0;
                cs_v = '1;
            end else begin
                drive_random(1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
